// File: rtl/hcm_reader.sv
// Issues row reads to the HCM, tracks outstanding reads with a fixed-latency tag pipeline,
// and buffers the decoded results in a credit-limited FIFO.
module hcm_reader #(
    parameter int ROWINDEXBITS_HCM = 10,
    parameter int MAXHITNBITS      = 3,
    parameter int ROWINDEXBITS_HIM = 8,
    parameter int NCOLS_HCM        = MAXHITNBITS + ROWINDEXBITS_HIM,
    parameter int READ_LATENCY     = 3,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        reqValid,
    input  logic [ROWINDEXBITS_HCM-1:0] reqRow,
    output logic                        reqReady,
    input  logic                        flush,
    output logic                        flushDone,
    input  logic                        hcmReadReady,
    input  logic                        hcmBusy,
    output logic                        hcmReadRow,
    output logic [ROWINDEXBITS_HCM-1:0] hcmRowToRead,
    input  logic [ROWINDEXBITS_HCM-1:0] hcmRowPassed,
    input  logic [NCOLS_HCM-1:0]        hcmRowReadOutput,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [ROWINDEXBITS_HCM-1:0] outRow,
    output logic [MAXHITNBITS-1:0]      outNHits,
    output logic [ROWINDEXBITS_HIM-1:0] outHIMAddress,
    output logic                        outEmpty,
    output logic                        errMismatch,
    output logic [2:0]                  inFlight
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int SUMW = ((CNTW > 3) ? CNTW : 3) + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t                        state_q, state_d;
    logic [2:0]                    in_flight_q, in_flight_d;
    logic                          err_q, err_d;
    logic                          read_row_q, read_row_d;
    logic [ROWINDEXBITS_HCM-1:0]   row_to_read_q, row_to_read_d;
    logic [READ_LATENCY-1:0]       pipe_valid_q, pipe_valid_d;
    logic [ROWINDEXBITS_HCM-1:0]   pipe_row_q [READ_LATENCY];
    logic [ROWINDEXBITS_HCM-1:0]   pipe_row_d [READ_LATENCY];
    logic [ROWINDEXBITS_HCM-1:0]   mem_row_q [DEPTH];
    logic [ROWINDEXBITS_HCM-1:0]   mem_row_d [DEPTH];
    logic [NCOLS_HCM-1:0]          mem_data_q [DEPTH];
    logic [NCOLS_HCM-1:0]          mem_data_d [DEPTH];
    logic [PTRW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]               fifo_count_q, fifo_count_d;

    logic [SUMW-1:0]               credit_used;
    logic                          can_accept, accept, cap_valid, push, pop;
    logic                          out_valid, flush_done;
    logic [ROWINDEXBITS_HCM-1:0]   cap_row, head_row;
    logic [NCOLS_HCM-1:0]          head_data;

    // Credits count every request that will eventually occupy a FIFO slot, so the FIFO cannot overflow.
    always_comb begin
        credit_used = SUMW'(in_flight_q) + SUMW'(fifo_count_q);
        can_accept  = resetN && (state_q != FLUSH) && hcmReadReady && !hcmBusy
                      && (credit_used < SUMW'(DEPTH));
        accept      = can_accept && reqValid;
        cap_valid   = pipe_valid_q[READ_LATENCY-1];
        cap_row     = pipe_row_q[READ_LATENCY-1];
        out_valid   = (fifo_count_q != '0) && (state_q != FLUSH);
        push        = cap_valid && (state_q != FLUSH);
        pop         = out_valid && outReady;
        flush_done  = (state_q == FLUSH) && (in_flight_q == 3'd0);
        head_row    = mem_row_q[rd_ptr_q];
        head_data   = mem_data_q[rd_ptr_q];
    end

    always_comb begin
        state_d       = state_q;
        read_row_d    = accept;
        row_to_read_d = accept ? reqRow : row_to_read_q;
        in_flight_d   = in_flight_q + 3'(accept) - 3'(cap_valid);
        err_d         = err_q | (cap_valid && (hcmRowPassed != cap_row));
        pipe_valid_d  = pipe_valid_q;
        pipe_row_d    = pipe_row_q;
        mem_row_d     = mem_row_q;
        mem_data_d    = mem_data_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_count_d  = fifo_count_q + CNTW'(push) - CNTW'(pop);

        pipe_valid_d[0] = read_row_q;
        pipe_row_d[0]   = row_to_read_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_row_d[i]   = pipe_row_q[i-1];
        end

        if (push) begin
            mem_row_d[wr_ptr_q]  = cap_row;
            mem_data_d[wr_ptr_q] = hcmRowReadOutput;
            wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        // A flush only finishes once every outstanding read has drained through the tag pipeline.
        case (state_q)
            FLUSH: begin
                if (in_flight_q == 3'd0) begin
                    state_d      = IDLE;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    fifo_count_d = '0;
                end
            end
            default: begin
                if (flush)
                    state_d = FLUSH;
                else if ((in_flight_d != 3'd0) || (fifo_count_d != '0))
                    state_d = ACTIVE;
                else
                    state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q       <= IDLE;
            in_flight_q   <= '0;
            err_q         <= 1'b0;
            read_row_q    <= 1'b0;
            row_to_read_q <= '0;
            pipe_valid_q  <= '0;
            pipe_row_q    <= '{default: '0};
            mem_row_q     <= '{default: '0};
            mem_data_q    <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            in_flight_q   <= in_flight_d;
            err_q         <= err_d;
            read_row_q    <= read_row_d;
            row_to_read_q <= row_to_read_d;
            pipe_valid_q  <= pipe_valid_d;
            pipe_row_q    <= pipe_row_d;
            mem_row_q     <= mem_row_d;
            mem_data_q    <= mem_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!resetN)
        !(push && !pop && (fifo_count_q == CNTW'(DEPTH))));

    assign reqReady      = can_accept;
    assign flushDone     = flush_done;
    assign hcmReadRow    = read_row_q;
    assign hcmRowToRead  = row_to_read_q;
    assign outValid      = out_valid;
    assign outRow        = out_valid ? head_row : '0;
    assign outNHits      = out_valid ? head_data[MAXHITNBITS-1:0] : '0;
    assign outHIMAddress = out_valid ? head_data[NCOLS_HCM-1:MAXHITNBITS] : '0;
    assign outEmpty      = out_valid && (head_data[MAXHITNBITS-1:0] == '0);
    assign errMismatch   = err_q;
    assign inFlight      = in_flight_q;

endmodule

// File: tb/tb_hcm_reader.sv
// Bench for hcm_reader: an HCM memory model with fixed read latency plus a queue-based
// scoreboard of accepted-but-unpopped requests.
module tb_hcm_reader;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetN, reqValid, reqReady, flush, flushDone;
    logic        hcmReadReady, hcmBusy, hcmReadRow;
    logic [9:0]  reqRow, hcmRowToRead, hcmRowPassed, outRow;
    logic [10:0] hcmRowReadOutput;
    logic        outValid, outReady, outEmpty, errMismatch;
    logic [2:0]  outNHits, inFlight;
    logic [7:0]  outHIMAddress;

    always #5 clk = ~clk;

    hcm_reader #(.ROWINDEXBITS_HCM(10), .MAXHITNBITS(3), .ROWINDEXBITS_HIM(8), .NCOLS_HCM(11),
                 .READ_LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqRow(reqRow), .reqReady(reqReady),
        .flush(flush), .flushDone(flushDone), .hcmReadReady(hcmReadReady), .hcmBusy(hcmBusy),
        .hcmReadRow(hcmReadRow), .hcmRowToRead(hcmRowToRead), .hcmRowPassed(hcmRowPassed),
        .hcmRowReadOutput(hcmRowReadOutput), .outValid(outValid), .outReady(outReady),
        .outRow(outRow), .outNHits(outNHits), .outHIMAddress(outHIMAddress), .outEmpty(outEmpty),
        .errMismatch(errMismatch), .inFlight(inFlight));

    typedef struct {
        logic [9:0]  row;
        logic [10:0] data;
        int          avail;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        exp_strobe = 1'b0;
    logic [9:0]  exp_row_to_read = '0;
    logic        mm_en = 1'b0;
    logic [9:0]  mm_row = '0;
    logic [10:0] hcm_mem [1024];

    // HCM model: answers every strobe LAT cycles later, optionally echoing a wrong row.
    logic [LAT-1:0] hv;
    logic [9:0]     hr [LAT];
    always @(posedge clk) begin
        hv <= {hv[LAT-2:0], hcmReadRow};
        hr[0] <= hcmRowToRead;
        for (int i = 1; i < LAT; i++) hr[i] <= hr[i-1];
    end
    assign hcmRowPassed = (hv[LAT-1] === 1'b1)
        ? ((mm_en && hr[LAT-1] == mm_row) ? hr[LAT-1] + 10'd1 : hr[LAT-1]) : 10'd0;
    assign hcmRowReadOutput = (hv[LAT-1] === 1'b1) ? hcm_mem[hr[LAT-1]] : 11'd0;

    // Updates the scoreboard from this cycle's handshakes, then advances one clock.
    task automatic tick();
        exp_t e;
        bit   acc;
        acc = resetN && reqValid && reqReady;
        if (!resetN) begin
            exp_q.delete();
            exp_strobe = 1'b0;
            exp_row_to_read = '0;
        end else begin
            if (outValid && outReady && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) begin
                e.row = reqRow; e.data = hcm_mem[reqRow]; e.avail = cyc + LAT + 2;
                exp_q.push_back(e);
            end
            if (flush) exp_q.delete();
            exp_strobe = acc;
            if (acc) exp_row_to_read = reqRow;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic int exp_in_flight();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].avail > cyc) n++;
        return n;
    endfunction

    task automatic test_reset();
        resetN = 1'b0; hcmReadReady = 1'b1; hcmBusy = 1'b0; reqValid = 1'b1; reqRow = 10'd7;
        flush = 1'b0; outReady = 1'b0;
        tick(); tick(); #1;
        checks++; if (reqReady !== 1'b0) begin errors++; $display("[TB] FAIL rst_reqReady: got %b expected 0", reqReady); end
        checks++; if (hcmReadRow !== 1'b0) begin errors++; $display("[TB] FAIL rst_hcmReadRow: got %b expected 0", hcmReadRow); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_outValid: got %b expected 0", outValid); end
        checks++; if (flushDone !== 1'b0) begin errors++; $display("[TB] FAIL rst_flushDone: got %b expected 0", flushDone); end
        checks++; if (errMismatch !== 1'b0) begin errors++; $display("[TB] FAIL rst_errMismatch: got %b expected 0", errMismatch); end
        checks++; if (outEmpty !== 1'b0) begin errors++; $display("[TB] FAIL rst_outEmpty: got %b expected 0", outEmpty); end
        checks++; if ({hcmRowToRead, outRow} !== 20'd0) begin errors++; $display("[TB] FAIL rst_rows: got %h/%h expected 0/0", hcmRowToRead, outRow); end
        checks++; if ({outNHits, outHIMAddress, inFlight} !== 14'd0) begin errors++; $display("[TB] FAIL rst_fields: got %h/%h/%h expected 0", outNHits, outHIMAddress, inFlight); end
        resetN = 1'b1; hcmReadReady = 1'b0; reqValid = 1'b0;
        #1;
        checks++; if (reqReady !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_reqReady: got %b expected 0", reqReady); end
        hcmReadReady = 1'b1;
        #1;
        checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL idle_reqReady: got %b expected 1", reqReady); end
        tick();
    endtask

    task automatic test_single_read();
        int strobe_cyc;
        hcm_mem[5] = 11'b00000111_010;
        outReady = 1'b0; reqRow = 10'd5; reqValid = 1'b1;
        #1;
        checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL single_reqReady: got %b expected 1", reqReady); end
        tick();
        reqValid = 1'b0; #1;
        strobe_cyc = cyc;
        checks++; if ({hcmReadRow, hcmRowToRead} !== {1'b1, 10'd5}) begin errors++; $display("[TB] FAIL single_strobe: got %b/%0d expected 1/5", hcmReadRow, hcmRowToRead); end
        tick(); #1;
        checks++; if (hcmReadRow !== 1'b0) begin errors++; $display("[TB] FAIL single_strobe_width: got %b expected 0", hcmReadRow); end
        for (int i = 0; i < 10 && outValid !== 1'b1; i++) begin tick(); #1; end
        checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL single_timeout: got outValid %b expected 1", outValid); end
        checks++; if (cyc - strobe_cyc != LAT + 1) begin errors++; $display("[TB] FAIL single_latency: got %0d expected %0d", cyc - strobe_cyc, LAT + 1); end
        checks++; if ({outRow, outHIMAddress, outNHits, outEmpty} !== {10'd5, 8'd7, 3'd2, 1'b0}) begin errors++; $display("[TB] FAIL single_data: got row %0d him %0d nhits %0d empty %b expected 5 7 2 0", outRow, outHIMAddress, outNHits, outEmpty); end
        tick(); #1;
        checks++; if ({outValid, outRow} !== {1'b1, 10'd5}) begin errors++; $display("[TB] FAIL single_hold: got %b/%0d expected 1/5", outValid, outRow); end
        outReady = 1'b1; #1;
        tick(); #1;
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL single_pop: got %b expected 0", outValid); end
    endtask

    task automatic test_back_to_back();
        outReady = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            reqRow = 10'(i); reqValid = 1'b1; #1;
            checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept%0d: got %b expected 1", i, reqReady); end
            tick();
        end
        reqValid = 1'b0; #1;
        checks++; if ({reqReady, inFlight} !== {1'b0, 3'd4}) begin errors++; $display("[TB] FAIL b2b_credit: got ready %b inFlight %0d expected 0 4", reqReady, inFlight); end
        repeat (6) tick();
        #1;
        checks++; if ({outValid, reqReady, inFlight} !== {1'b1, 1'b0, 3'd0}) begin errors++; $display("[TB] FAIL b2b_full: got %b %b %0d expected 1 0 0", outValid, reqReady, inFlight); end
        outReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if ({outValid, outRow, outNHits, outHIMAddress} !== {1'b1, 10'(i), hcm_mem[i][2:0], hcm_mem[i][10:3]}) begin errors++; $display("[TB] FAIL b2b_drain%0d: got %b row %0d nh %0d him %0d expected row %0d", i, outValid, outRow, outNHits, outHIMAddress, i); end
            tick();
        end
        #1;
        checks++; if ({outValid, reqReady} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_after: got %b %b expected 0 1", outValid, reqReady); end
    endtask

    task automatic test_hcm_backpressure();
        hcmReadReady = 1'b0; reqValid = 1'b1; reqRow = 10'd20; outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (reqReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_reqReady%0d: got %b expected 0", i, reqReady); end
            tick(); #1;
            checks++; if (hcmReadRow !== 1'b0) begin errors++; $display("[TB] FAIL bp_strobe%0d: got %b expected 0", i, hcmReadRow); end
        end
        hcmReadReady = 1'b1; #1;
        checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got %b expected 1", reqReady); end
        tick();
        reqValid = 1'b0; #1;
        checks++; if ({hcmReadRow, hcmRowToRead} !== {1'b1, 10'd20}) begin errors++; $display("[TB] FAIL bp_strobe: got %b/%0d expected 1/20", hcmReadRow, hcmRowToRead); end
        hcmBusy = 1'b1; reqValid = 1'b1; reqRow = 10'd21; #1;
        checks++; if (reqReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_busy: got %b expected 0", reqReady); end
        tick();
        hcmBusy = 1'b0; reqValid = 1'b0; #1;
        for (int i = 0; i < 10 && outValid !== 1'b1; i++) begin tick(); #1; end
        checks++; if ({outValid, outRow} !== {1'b1, 10'd20}) begin errors++; $display("[TB] FAIL bp_result: got %b/%0d expected 1/20", outValid, outRow); end
        tick(); #1;
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_only_one: got %b expected 0", outValid); end
    endtask

    task automatic test_mismatch();
        #1;
        checks++; if (errMismatch !== 1'b0) begin errors++; $display("[TB] FAIL mm_before: got %b expected 0", errMismatch); end
        mm_en = 1'b1; mm_row = 10'd8; outReady = 1'b0; reqRow = 10'd8; reqValid = 1'b1; #1;
        tick();
        reqValid = 1'b0; #1;
        for (int i = 0; i < 10 && outValid !== 1'b1; i++) begin tick(); #1; end
        checks++; if ({errMismatch, outValid, outRow} !== {1'b1, 1'b1, 10'd8}) begin errors++; $display("[TB] FAIL mm_entry: got err %b valid %b row %0d expected 1 1 8", errMismatch, outValid, outRow); end
        checks++; if (outHIMAddress !== hcm_mem[8][10:3]) begin errors++; $display("[TB] FAIL mm_data: got %0d expected %0d", outHIMAddress, hcm_mem[8][10:3]); end
        outReady = 1'b1; #1;
        tick();
        mm_en = 1'b0;
        repeat (3) tick();
        #1;
        checks++; if (errMismatch !== 1'b1) begin errors++; $display("[TB] FAIL mm_sticky: got %b expected 1", errMismatch); end
    endtask

    task automatic test_flush();
        int fc;
        outReady = 1'b0;
        for (int r = 30; r <= 31; r++) begin reqRow = 10'(r); reqValid = 1'b1; #1; tick(); end
        reqValid = 1'b0;
        repeat (6) tick();
        #1;
        checks++; if ({outValid, inFlight} !== {1'b1, 3'd0}) begin errors++; $display("[TB] FAIL fl_prefill: got %b %0d expected 1 0", outValid, inFlight); end
        for (int r = 32; r <= 33; r++) begin reqRow = 10'(r); reqValid = 1'b1; #1; tick(); end
        reqValid = 1'b0; flush = 1'b1; #1;
        checks++; if (inFlight !== 3'd2) begin errors++; $display("[TB] FAIL fl_inflight: got %0d expected 2", inFlight); end
        fc = cyc;
        tick();
        flush = 1'b0; #1;
        checks++; if ({outValid, reqReady} !== 2'b00) begin errors++; $display("[TB] FAIL fl_enter: got valid %b ready %b expected 0 0", outValid, reqReady); end
        for (int i = 0; i < 10 && flushDone !== 1'b1; i++) begin tick(); #1; end
        checks++; if ({flushDone, inFlight} !== {1'b1, 3'd0}) begin errors++; $display("[TB] FAIL fl_done: got %b %0d expected 1 0", flushDone, inFlight); end
        checks++; if (cyc - fc != LAT + 1) begin errors++; $display("[TB] FAIL fl_done_cycle: got %0d expected %0d", cyc - fc, LAT + 1); end
        tick(); #1;
        checks++; if ({flushDone, outValid, reqReady} !== 3'b001) begin errors++; $display("[TB] FAIL fl_after: got %b %b %b expected 0 0 1", flushDone, outValid, reqReady); end
        flush = 1'b1; #1;
        tick();
        flush = 1'b0; #1;
        checks++; if (flushDone !== 1'b1) begin errors++; $display("[TB] FAIL fl_idle: got %b expected 1", flushDone); end
        tick(); #1;
        checks++; if (flushDone !== 1'b0) begin errors++; $display("[TB] FAIL fl_idle_pulse: got %b expected 0", flushDone); end
    endtask

    task automatic test_reset_midop();
        outReady = 1'b1;
        for (int r = 41; r <= 43; r++) begin reqRow = 10'(r); reqValid = 1'b1; #1; tick(); end
        reqValid = 1'b0; resetN = 1'b0; #1;
        tick(); tick(); #1;
        checks++; if ({reqReady, hcmReadRow, outValid, flushDone, errMismatch, outEmpty} !== 6'd0) begin errors++; $display("[TB] FAIL rm_flags: got %b%b%b%b%b%b expected 000000", reqReady, hcmReadRow, outValid, flushDone, errMismatch, outEmpty); end
        checks++; if ({hcmRowToRead, outRow, outNHits, outHIMAddress, inFlight} !== 34'd0) begin errors++; $display("[TB] FAIL rm_fields: got %h %h %h %h %h expected 0", hcmRowToRead, outRow, outNHits, outHIMAddress, inFlight); end
        resetN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            checks++; if ({outValid, inFlight} !== {1'b0, 3'd0}) begin errors++; $display("[TB] FAIL rm_ignore%0d: got %b %0d expected 0 0", i, outValid, inFlight); end
        end
    endtask

    task automatic test_random();
        logic exp_rr, exp_ov;
        for (int i = 0; i < 460; i++) begin
            reqValid     = (i < 400) && ($urandom_range(0, 9) < 7);
            reqRow       = 10'($urandom_range(0, 1023));
            outReady     = (i >= 400) || ($urandom_range(0, 9) < 6);
            hcmReadReady = (i >= 400) || ($urandom_range(0, 9) < 8);
            hcmBusy      = (i < 400) && ($urandom_range(0, 9) == 0);
            #1;
            exp_rr = hcmReadReady && !hcmBusy && (exp_q.size() < DEPTH);
            exp_ov = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            checks++; if (reqReady !== exp_rr) begin errors++; $display("[TB] FAIL rnd_reqReady c%0d: got %b expected %b", cyc, reqReady, exp_rr); end
            checks++; if (outValid !== exp_ov) begin errors++; $display("[TB] FAIL rnd_outValid c%0d: got %b expected %b", cyc, outValid, exp_ov); end
            checks++; if ({hcmReadRow, hcmRowToRead} !== {exp_strobe, exp_row_to_read}) begin errors++; $display("[TB] FAIL rnd_strobe c%0d: got %b/%0d expected %b/%0d", cyc, hcmReadRow, hcmRowToRead, exp_strobe, exp_row_to_read); end
            checks++; if (inFlight !== 3'(exp_in_flight())) begin errors++; $display("[TB] FAIL rnd_inFlight c%0d: got %0d expected %0d", cyc, inFlight, exp_in_flight()); end
            checks++; if (errMismatch !== 1'b0) begin errors++; $display("[TB] FAIL rnd_err c%0d: got %b expected 0", cyc, errMismatch); end
            if (exp_ov && outValid === 1'b1) begin
                checks++;
                if ({outRow, outNHits, outHIMAddress, outEmpty} !== {exp_q[0].row, exp_q[0].data[2:0], exp_q[0].data[10:3], exp_q[0].data[2:0] == 3'd0}) begin
                    errors++;
                    $display("[TB] FAIL rnd_head c%0d: got row %0d nh %0d him %0d empty %b expected row %0d data %h", cyc, outRow, outNHits, outHIMAddress, outEmpty, exp_q[0].row, exp_q[0].data);
                end
            end
            tick();
        end
        #1;
        checks++; if ({outValid, inFlight} !== {1'b0, 3'd0} || exp_q.size() != 0) begin errors++; $display("[TB] FAIL rnd_drain: got %b %0d model %0d expected 0 0 0", outValid, inFlight, exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) hcm_mem[i] = 11'($urandom);
        resetN = 1'b0; reqValid = 1'b0; reqRow = '0; flush = 1'b0;
        hcmReadReady = 1'b1; hcmBusy = 1'b0; outReady = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_hcm_backpressure();
        test_mismatch();
        test_flush();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
